// File: rtl/com_pkg.sv
`default_nettype none
// ============================================================================
// Module      : com_pkg
// Description : Shared definitions for the Com command-path blocks.
//               - sequencer state encoding used by com_arbiter
//               - default command-word and timeout-counter widths
//               - field offsets inside a 16-bit command word
// Revision    : 1.0 - initial release
// ============================================================================
package com_pkg;

    // Default widths for the command path
    localparam int COM_DEF_CMD_W = 16;
    localparam int COM_DEF_TO_W  = 8;

    // Command-word layout: [15:12] opcode, [11:8] register address,
    // [7:0] payload. The arbiter treats the word as opaque; the
    // command-write controller and decoders use these offsets.
    localparam int COM_OP_LSB    = 12;
    localparam int COM_OP_W      = 4;
    localparam int COM_ADDR_LSB  = 8;
    localparam int COM_ADDR_W    = 4;
    localparam int COM_DATA_LSB  = 0;
    localparam int COM_DATA_W    = 8;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } com_state_e;

endpackage : com_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotate-priority encoder. Scans req starting
//               at ptr+1, wrapping round, and reports the first set bit.
//               The requester at ptr itself is checked last, so whoever
//               was served most recently has the lowest priority.
// Ports       : req    [N-1:0]      request vector
//               ptr    [IDX_W-1:0]  index of the most recently served
//               winner [IDX_W-1:0]  selected index (0 when valid is low)
//               valid               at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    always_comb begin
        int idx;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        // Walk the offsets from farthest to nearest; the nearest set bit is
        // written last and therefore wins. Modulo keeps non-power-of-two N
        // inside the request vector.
        for (int off = N; off >= 1; off--) begin
            idx = (int'(ptr) + off) % N;
            if (req[idx]) begin
                winner = IDX_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/com_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : com_arbiter
// Description : Round-robin arbiter/sequencer sharing one command write
//               channel among N_REQ requesters. One command at a time is
//               granted, issued as a single-cycle write strobe with latched
//               data, then the block waits for the channel's completion
//               pulse or a timeout of 2**TO_W-1 cycles.
// Ports       : clk, reset        clock, synchronous active-high reset
//               req[N_REQ]        per-requester command pending
//               cmd_in            requester i word at [i*CMD_W +: CMD_W]
//               grant[N_REQ]      one-hot pulse, word taken
//               cmd_out[CMD_W]    latched command word
//               cmd_write         single-cycle write strobe
//               cmd_done          channel completion pulse
//               busy              command in flight (ISSUE or WAIT)
//               owner             current / most recent winner index
//               timeout_err       pulse when the wait expires
// Revision    : 1.0 - initial release
// ============================================================================
module com_arbiter
    import com_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int CMD_W = COM_DEF_CMD_W,
    parameter  int TO_W  = COM_DEF_TO_W,
    localparam int OWN_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CMD_W-1:0] cmd_in,
    output logic [N_REQ-1:0]       grant,
    output logic [CMD_W-1:0]       cmd_out,
    output logic                   cmd_write,
    input  logic                   cmd_done,
    output logic                   busy,
    output logic [OWN_W-1:0]       owner,
    output logic                   timeout_err
);

    // Last WAIT cycle is the one where the timer holds all-ones minus one,
    // giving 2**TO_W-1 WAIT cycles (timer values 0 .. 2**TO_W-2).
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [OWN_W-1:0] PTR_RST = OWN_W'(N_REQ - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    com_state_e         state_q, state_d;
    logic [OWN_W-1:0]   ptr_q, ptr_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [TO_W-1:0]    timer_q, timer_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               write_q, write_d;
    logic               busy_q, busy_d;
    logic               to_err_q, to_err_d;

    // ------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------
    logic [OWN_W-1:0]   pick_winner;
    logic               pick_valid;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (OWN_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // ------------------------------------------------------------------
    // Next-state logic. Strobe-type outputs are decoded from the current
    // state and registered, so they appear one cycle after the state is
    // entered (write/grant during the cycle after ISSUE, busy one cycle
    // behind the state).
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        cmd_d    = cmd_q;
        timer_d  = timer_q;
        grant_d  = '0;
        write_d  = 1'b0;
        to_err_d = 1'b0;
        busy_d   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

        case (state_q)
            ST_IDLE: begin
                // req is only looked at here; changes in ISSUE/WAIT are ignored
                if (pick_valid) begin
                    owner_d = pick_winner;
                    cmd_d   = cmd_in[int'(pick_winner)*CMD_W +: CMD_W];
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                write_d          = 1'b1;
                grant_d[owner_q] = 1'b1;
                timer_d          = '0;
                // Served requester becomes lowest priority for next round
                ptr_d            = owner_q;
                state_d          = ST_WAIT;
            end

            ST_WAIT: begin
                timer_d = timer_q + 1'b1;
                // Completion takes precedence over a simultaneous expiry
                if (cmd_done) begin
                    state_d = ST_IDLE;
                end else if (timer_q == TO_LAST) begin
                    to_err_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PTR_RST;
            owner_q  <= '0;
            cmd_q    <= '0;
            timer_q  <= '0;
            grant_q  <= '0;
            write_q  <= 1'b0;
            busy_q   <= 1'b0;
            to_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            cmd_q    <= cmd_d;
            timer_q  <= timer_d;
            grant_q  <= grant_d;
            write_q  <= write_d;
            busy_q   <= busy_d;
            to_err_q <= to_err_d;
        end
    end

    assign grant       = grant_q;
    assign cmd_out     = cmd_q;
    assign cmd_write   = write_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign timeout_err = to_err_q;

endmodule : com_arbiter
`default_nettype wire

// File: tb/tb_com_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_com_arbiter
// Description : Self-checking bench for com_arbiter (N_REQ=4, CMD_W=16,
//               TO_W=8). Directed table and sequences, then random
//               stimulus against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_com_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TOW = 8;
    localparam int TO_CYC = (1 << TOW) - 1;

    logic           clk      = 1'b0;
    logic           reset    = 1'b1;
    logic [N-1:0]   req      = '0;
    logic [N*W-1:0] cmd_in   = '0;
    logic           cmd_done = 1'b0;
    logic [N-1:0]   grant;
    logic [W-1:0]   cmd_out;
    logic           cmd_write;
    logic           busy;
    logic [1:0]     owner;
    logic           timeout_err;

    always #5 clk = ~clk;

    com_arbiter #(
        .N_REQ (N),
        .CMD_W (W),
        .TO_W  (TOW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .cmd_in      (cmd_in),
        .grant       (grant),
        .cmd_out     (cmd_out),
        .cmd_write   (cmd_write),
        .cmd_done    (cmd_done),
        .busy        (busy),
        .owner       (owner),
        .timeout_err (timeout_err)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Directed command words: {w3, w2, w1, w0}
    localparam logic [N*W-1:0] DIR_WORDS = {16'hC003, 16'hBEEF, 16'hC001, 16'h5A00};

    // ------------------------------------------------------------------
    // Reference model: tracks "age" = edges since the arbitration
    // decision of the transaction in flight (-1 when none).
    // age 0 -> strobe on the next edge, age 1..TO_CYC -> waiting.
    // ------------------------------------------------------------------
    int           m_age  = -1;
    int           m_last = N - 1;
    int           m_own  = 0;
    logic [W-1:0] m_cmd  = '0;
    logic         m_busy = 1'b0;
    logic         m_wr   = 1'b0;
    logic         m_to   = 1'b0;
    logic [N-1:0] m_gnt  = '0;

    function automatic void model_edge();
        if (reset) begin
            m_age = -1; m_last = N - 1; m_own = 0; m_cmd = '0;
            m_busy = 1'b0; m_wr = 1'b0; m_to = 1'b0; m_gnt = '0;
        end else begin
            m_busy = (m_age >= 0);
            m_wr   = 1'b0;
            m_to   = 1'b0;
            m_gnt  = '0;
            if (m_age < 0) begin
                for (int off = N; off >= 1; off--) begin
                    int i;
                    i = (m_last + off) % N;
                    if (req[i]) begin
                        m_own = i;
                        m_age = 0;
                    end
                end
                if (m_age == 0) m_cmd = cmd_in[m_own*W +: W];
            end else if (m_age == 0) begin
                m_age  = 1;
                m_wr   = 1'b1;
                m_gnt  = N'(1) << m_own;
                m_last = m_own;
            end else if (cmd_done) begin
                m_age = -1;
            end else if (m_age == TO_CYC) begin
                m_age = -1;
                m_to  = 1'b1;
            end else begin
                m_age++;
            end
        end
    endfunction

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // One clock: model consumes the inputs sampled at this edge, then the
    // DUT outputs are compared 1ns after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check("model_grant",   64'(grant),       64'(m_gnt));
        check("model_cmd_out", 64'(cmd_out),     64'(m_cmd));
        check("model_write",   64'(cmd_write),   64'(m_wr));
        check("model_busy",    64'(busy),        64'(m_busy));
        check("model_owner",   64'(owner),       64'(m_own));
        check("model_timeout", 64'(timeout_err), 64'(m_to));
    endtask

    task automatic wait_write(input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (cmd_write !== 1'b1 && k < budget);
        check("wait_write_seen", 64'(cmd_write), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (busy !== 1'b0 && k < budget);
        check("wait_idle_seen", 64'(busy), 64'd0);
    endtask

    task automatic finish_cmd();
        step();
        step();
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
        wait_idle(20);
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [1:0]   exp_owner;
        logic [W-1:0] exp_cmd;
        logic [N-1:0] exp_grant;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int last_w;

        // Starting from reset (ptr = 3), each entry is served in turn
        tbl[0] = '{4'b1111, 2'd0, 16'h5A00, 4'b0001};
        tbl[1] = '{4'b1111, 2'd1, 16'hC001, 4'b0010};
        tbl[2] = '{4'b1111, 2'd2, 16'hBEEF, 4'b0100};
        tbl[3] = '{4'b1111, 2'd3, 16'hC003, 4'b1000};
        tbl[4] = '{4'b1111, 2'd0, 16'h5A00, 4'b0001};
        tbl[5] = '{4'b0100, 2'd2, 16'hBEEF, 4'b0100};
        tbl[6] = '{4'b0101, 2'd0, 16'h5A00, 4'b0001};
        tbl[7] = '{4'b1001, 2'd3, 16'hC003, 4'b1000};
        tbl[8] = '{4'b0110, 2'd1, 16'hC001, 4'b0010};
        tbl[9] = '{4'b0011, 2'd0, 16'h5A00, 4'b0001};

        // ---- Reset values with all requests pending ----
        cmd_in = DIR_WORDS;
        reset  = 1'b1;
        req    = 4'b1111;
        step();
        step();
        check("rst_grant",   64'(grant),       64'd0);
        check("rst_write",   64'(cmd_write),   64'd0);
        check("rst_busy",    64'(busy),        64'd0);
        check("rst_timeout", 64'(timeout_err), 64'd0);
        check("rst_cmd_out", 64'(cmd_out),     64'd0);
        check("rst_owner",   64'(owner),       64'd0);
        reset = 1'b0;

        // ---- Round-robin order and 5-cycle period ----
        last_w = 0;
        for (int g = 0; g <= N; g++) begin
            wait_write(10);
            check("rr_owner", 64'(owner), 64'(g % N));
            check("rr_grant", 64'(grant), 64'(N'(1) << (g % N)));
            if (g == 0) check("rr_first_cmd", 64'(cmd_out), 64'h5A00);
            if (g > 0)  check("rr_period", 64'(cyc - last_w), 64'd5);
            last_w = cyc;
            if (g == N) req = '0;
            step();
            step();
            cmd_done = 1'b1;
            step();
            cmd_done = 1'b0;
        end
        wait_idle(20);

        // ---- Table-driven arbitration from a fresh reset ----
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int t = 0; t < 10; t++) begin
            req = tbl[t].req;
            wait_write(10);
            check("tbl_owner",   64'(owner),   64'(tbl[t].exp_owner));
            check("tbl_cmd_out", 64'(cmd_out), 64'(tbl[t].exp_cmd));
            check("tbl_grant",   64'(grant),   64'(tbl[t].exp_grant));
            req = '0;
            finish_cmd();
        end

        // ---- Timeout, then next requester served ----
        req = 4'b0001;
        wait_write(10);
        check("to_owner0", 64'(owner), 64'd0);
        last_w = cyc;
        req = 4'b0010;
        for (int k = 0; k < 300 && timeout_err !== 1'b1; k++) step();
        check("to_seen", 64'(timeout_err), 64'd1);
        check("to_delay", 64'(cyc - last_w), 64'(TO_CYC));
        step();
        check("to_single_pulse", 64'(timeout_err), 64'd0);
        check("to_busy_fall", 64'(busy), 64'd0);
        wait_write(10);
        check("to_next_owner", 64'(owner), 64'd1);
        req = '0;
        finish_cmd();

        // ---- Done coincident with timer expiry ----
        req = 4'b0100;
        wait_write(10);
        last_w = cyc;
        req = '0;
        while (cyc < last_w + TO_CYC - 1) step();
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
        check("tie_no_timeout", 64'(timeout_err), 64'd0);
        step();
        check("tie_idle", 64'(busy), 64'd0);
        check("tie_no_timeout_late", 64'(timeout_err), 64'd0);

        // ---- Reset during WAIT ----
        req = 4'b1000;
        wait_write(10);
        req = '0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rw_busy",    64'(busy),      64'd0);
        check("rw_write",   64'(cmd_write), 64'd0);
        check("rw_grant",   64'(grant),     64'd0);
        check("rw_cmd_out", 64'(cmd_out),   64'd0);
        check("rw_owner",   64'(owner),     64'd0);

        // ---- Reset while ISSUE is pending: no grant for it ----
        req = 4'b1000;
        step();
        reset = 1'b1;
        req   = '0;
        step();
        reset = 1'b0;
        check("ri_grant", 64'(grant),     64'd0);
        check("ri_write", 64'(cmd_write), 64'd0);
        step();
        check("ri_grant_late", 64'(grant),     64'd0);
        check("ri_write_late", 64'(cmd_write), 64'd0);
        check("ri_busy_late",  64'(busy),      64'd0);

        // ---- Stray done in IDLE ----
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
        step();
        check("stray_busy",  64'(busy),      64'd0);
        check("stray_write", 64'(cmd_write), 64'd0);
        req = 4'b1111;
        wait_write(10);
        check("stray_owner", 64'(owner), 64'd0);
        req = '0;
        finish_cmd();

        // ---- Random stimulus, frequent completions ----
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            req      = N'($urandom_range(0, 15));
            cmd_in   = {$urandom, $urandom};
            cmd_done = ($urandom_range(0, 3) == 0);
            step();
        end

        // ---- Random stimulus, rare completions (timeouts occur) ----
        reset = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            req      = N'($urandom_range(0, 15));
            cmd_in   = {$urandom, $urandom};
            cmd_done = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_com_arbiter
`default_nettype wire
